axi_rd_arbiter: RTL and testbench

Two-master, one-slave AXI4 read-channel arbiter sitting directly downstream of the instruction cache's refill port (`out_*`). It merges the cache's refill bursts with the LSU's read requests onto the single memory-side read port. One transaction is outstanding at a time. Bursts are never interleaved: a grant is held until the slave's last beat is accepted.

---
 rtl/axi_rd_arbiter.sv | 151 +++++++++++++++
 tb/tb_axi_rd_arbiter.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_rd_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : axi_rd_arbiter
// Brief    : Two-master AXI4 read arbiter (m0 = icache, m1 = LSU), one burst
//            outstanding. ARB_ROUND_ROBIN_EN selects round-robin; default is
//            fixed m0 priority.
// Revision : 1.0
// ============================================================================
module axi_rd_arbiter #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32,
   parameter int ID_WIDTH   = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  m0_arvalid,
   output logic                  m0_arready,
   input  logic [ADDR_WIDTH-1:0] m0_araddr,
   input  logic [ID_WIDTH-1:0]   m0_arid,
   input  logic [7:0]            m0_arlen,
   input  logic [2:0]            m0_arsize,
   input  logic [1:0]            m0_arburst,
   input  logic                  m0_rready,
   output logic                  m0_rvalid,
   output logic [1:0]            m0_rresp,
   output logic [DATA_WIDTH-1:0] m0_rdata,
   output logic                  m0_rlast,
   output logic [ID_WIDTH-1:0]   m0_rid,
   input  logic                  m1_arvalid,
   output logic                  m1_arready,
   input  logic [ADDR_WIDTH-1:0] m1_araddr,
   input  logic [ID_WIDTH-1:0]   m1_arid,
   input  logic [7:0]            m1_arlen,
   input  logic [2:0]            m1_arsize,
   input  logic [1:0]            m1_arburst,
   input  logic                  m1_rready,
   output logic                  m1_rvalid,
   output logic [1:0]            m1_rresp,
   output logic [DATA_WIDTH-1:0] m1_rdata,
   output logic                  m1_rlast,
   output logic [ID_WIDTH-1:0]   m1_rid,
   output logic                  s_arvalid,
   input  logic                  s_arready,
   output logic [ADDR_WIDTH-1:0] s_araddr,
   output logic [ID_WIDTH-1:0]   s_arid,
   output logic [7:0]            s_arlen,
   output logic [2:0]            s_arsize,
   output logic [1:0]            s_arburst,
   input  logic                  s_rvalid,
   output logic                  s_rready,
   input  logic [1:0]            s_rresp,
   input  logic [DATA_WIDTH-1:0] s_rdata,
   input  logic                  s_rlast,
   input  logic [ID_WIDTH-1:0]   s_rid
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_ADDR = 2'd1,
      ST_DATA = 2'd2
   } state_t;

   state_t r_state;
   logic   r_gnt;
   logic   w_req;
   logic   w_win;
   logic   w_idle;
   logic   w_data;
   logic   w_r0;
   logic   w_r1;

   assign w_req = m0_arvalid | m1_arvalid;

`ifdef ARB_ROUND_ROBIN_EN
   logic r_last;
   assign w_win = (m0_arvalid & m1_arvalid) ? ~r_last : m1_arvalid;
`else
   assign w_win = ~m0_arvalid;
`endif

   // Handshake and data outputs are gated by rst so nothing leaks in the reset cycle
   assign w_idle = (r_state == ST_IDLE) & ~rst;
   assign w_data = (r_state == ST_DATA) & ~rst;

   assign m0_arready = w_idle & m0_arvalid & ~w_win;
   assign m1_arready = w_idle & m1_arvalid &  w_win;

   assign w_r0     = w_data & ~r_gnt;
   assign w_r1     = w_data &  r_gnt;
   assign s_rready = w_data & (r_gnt ? m1_rready : m0_rready);

   assign m0_rvalid = w_r0 & s_rvalid;
   assign m0_rresp  = w_r0 ? s_rresp : 2'b00;
   assign m0_rdata  = w_r0 ? s_rdata : '0;
   assign m0_rlast  = w_r0 & s_rlast;
   assign m0_rid    = w_r0 ? s_rid : '0;

   assign m1_rvalid = w_r1 & s_rvalid;
   assign m1_rresp  = w_r1 ? s_rresp : 2'b00;
   assign m1_rdata  = w_r1 ? s_rdata : '0;
   assign m1_rlast  = w_r1 & s_rlast;
   assign m1_rid    = w_r1 ? s_rid : '0;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state   <= ST_IDLE;
         r_gnt     <= 1'b0;
         s_arvalid <= 1'b0;
         s_araddr  <= '0;
         s_arid    <= '0;
         s_arlen   <= 8'd0;
         s_arsize  <= 3'd0;
         s_arburst <= 2'd0;
`ifdef ARB_ROUND_ROBIN_EN
         r_last    <= 1'b1;
`endif
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (w_req) begin
                  r_gnt     <= w_win;
                  s_arvalid <= 1'b1;
                  s_araddr  <= w_win ? m1_araddr  : m0_araddr;
                  s_arid    <= w_win ? m1_arid    : m0_arid;
                  s_arlen   <= w_win ? m1_arlen   : m0_arlen;
                  s_arsize  <= w_win ? m1_arsize  : m0_arsize;
                  s_arburst <= w_win ? m1_arburst : m0_arburst;
`ifdef ARB_ROUND_ROBIN_EN
                  r_last    <= w_win;
`endif
                  r_state   <= ST_ADDR;
               end
            end
            ST_ADDR: begin
               if (s_arready) begin
                  s_arvalid <= 1'b0;
                  r_state   <= ST_DATA;
               end
            end
            ST_DATA: begin
               // Only the slave's rlast ends the burst; beats are not counted
               if (s_rvalid & s_rready & s_rlast)
                  r_state <= ST_IDLE;
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_axi_rd_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_axi_rd_arbiter
// Brief    : Directed scoreboard bench for axi_rd_arbiter (both arbitration modes).
// Revision : 1.0
// ============================================================================
module tb_axi_rd_arbiter;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        m0_arvalid, m0_arready, m0_rready, m0_rvalid, m0_rlast;
   logic [31:0] m0_araddr, m0_rdata;
   logic [3:0]  m0_arid, m0_rid;
   logic [7:0]  m0_arlen;
   logic [2:0]  m0_arsize;
   logic [1:0]  m0_arburst, m0_rresp;
   logic        m1_arvalid, m1_arready, m1_rready, m1_rvalid, m1_rlast;
   logic [31:0] m1_araddr, m1_rdata;
   logic [3:0]  m1_arid, m1_rid;
   logic [7:0]  m1_arlen;
   logic [2:0]  m1_arsize;
   logic [1:0]  m1_arburst, m1_rresp;
   logic        s_arvalid, s_arready, s_rvalid, s_rready, s_rlast;
   logic [31:0] s_araddr, s_rdata;
   logic [3:0]  s_arid, s_rid;
   logic [7:0]  s_arlen;
   logic [2:0]  s_arsize;
   logic [1:0]  s_arburst, s_rresp;

   int          checks = 0;
   int          errors = 0;
   int          tb_last = 1;
   logic [48:0] ar_q[$];
   logic [39:0] r_q[$];
   logic [48:0] e_ar;
   logic [39:0] e_r;

   always #5 clk = ~clk;

   axi_rd_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .ID_WIDTH(4)) dut (
      .clk(clk), .rst(rst),
      .m0_arvalid(m0_arvalid), .m0_arready(m0_arready), .m0_araddr(m0_araddr),
      .m0_arid(m0_arid), .m0_arlen(m0_arlen), .m0_arsize(m0_arsize), .m0_arburst(m0_arburst),
      .m0_rready(m0_rready), .m0_rvalid(m0_rvalid), .m0_rresp(m0_rresp),
      .m0_rdata(m0_rdata), .m0_rlast(m0_rlast), .m0_rid(m0_rid),
      .m1_arvalid(m1_arvalid), .m1_arready(m1_arready), .m1_araddr(m1_araddr),
      .m1_arid(m1_arid), .m1_arlen(m1_arlen), .m1_arsize(m1_arsize), .m1_arburst(m1_arburst),
      .m1_rready(m1_rready), .m1_rvalid(m1_rvalid), .m1_rresp(m1_rresp),
      .m1_rdata(m1_rdata), .m1_rlast(m1_rlast), .m1_rid(m1_rid),
      .s_arvalid(s_arvalid), .s_arready(s_arready), .s_araddr(s_araddr), .s_arid(s_arid),
      .s_arlen(s_arlen), .s_arsize(s_arsize), .s_arburst(s_arburst),
      .s_rvalid(s_rvalid), .s_rready(s_rready), .s_rresp(s_rresp),
      .s_rdata(s_rdata), .s_rlast(s_rlast), .s_rid(s_rid)
   );

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Scoreboard monitor: pops an expectation on every slave AR and master R handshake
   always @(negedge clk) begin
      if (!rst) begin
         if (m0_arvalid && m1_arvalid)
            chk("arready_onehot", {63'd0, m0_arready & m1_arready}, 64'd0);
         if (s_arvalid && s_arready) begin
            if (ar_q.size() == 0) chk("ar_unexpected", {15'd0, s_araddr, s_arid, s_arlen, s_arsize, s_arburst}, 64'd0);
            else begin
               e_ar = ar_q.pop_front();
               chk("ar_fields", {15'd0, s_araddr, s_arid, s_arlen, s_arsize, s_arburst}, {15'd0, e_ar});
            end
         end
         if (m0_rvalid && m0_rready) begin
            if (r_q.size() == 0) chk("r_unexpected_m0", {24'd0, 1'b0, m0_rdata, m0_rid, m0_rresp, m0_rlast}, 64'd0);
            else begin
               e_r = r_q.pop_front();
               chk("r_beat_m0", {24'd0, 1'b0, m0_rdata, m0_rid, m0_rresp, m0_rlast}, {24'd0, e_r});
            end
         end
         if (m1_rvalid && m1_rready) begin
            if (r_q.size() == 0) chk("r_unexpected_m1", {24'd0, 1'b1, m1_rdata, m1_rid, m1_rresp, m1_rlast}, 64'd0);
            else begin
               e_r = r_q.pop_front();
               chk("r_beat_m1", {24'd0, 1'b1, m1_rdata, m1_rid, m1_rresp, m1_rlast}, {24'd0, e_r});
            end
         end
      end
   end

   task automatic master_ar(input int m, input logic [31:0] a, input logic [3:0] id,
                            input logic [7:0] len, output int waited);
      bit got;
      got = 1'b0;
      if (m == 0) begin
         m0_araddr = a; m0_arid = id; m0_arlen = len; m0_arsize = 3'd2; m0_arburst = 2'd1; m0_arvalid = 1'b1;
      end else begin
         m1_araddr = a; m1_arid = id; m1_arlen = len; m1_arsize = 3'd2; m1_arburst = 2'd1; m1_arvalid = 1'b1;
      end
      ar_q.push_back({a, id, len, 3'd2, 2'd1});
      waited = 0;
      for (int i = 0; i < 20 && !got; i++) begin
         @(negedge clk);
         if ((m == 0 && m0_arready) || (m == 1 && m1_arready)) got = 1'b1;
         else begin
            waited++;
            @(posedge clk); #1;
         end
      end
      if (!got) chk("ar_grant_timeout", 64'd0, 64'd1);
      @(posedge clk); #1;
      if (m == 0) m0_arvalid = 1'b0;
      else        m1_arvalid = 1'b0;
      tb_last = m;
   endtask

   task automatic slave_ar(input int delay, input logic [31:0] ea, input logic [3:0] eid,
                           input logic [7:0] elen);
      for (int i = 0; i <= delay; i++) begin
         s_arready = (i == delay);
         @(negedge clk);
         chk("s_arvalid_held", {63'd0, s_arvalid}, 64'd1);
         chk("s_araddr_held", {32'd0, s_araddr}, {32'd0, ea});
         chk("s_arid_len_held", {52'd0, s_arid, s_arlen}, {52'd0, eid, elen});
         chk("no_arready_in_addr", {62'd0, m0_arready, m1_arready}, 64'd0);
         @(posedge clk); #1;
      end
      s_arready = 1'b0;
   endtask

   task automatic slave_r(input int m, input int n, input logic [31:0] d0, input logic [31:0] step,
                          input logic [3:0] rid, input bit with_last);
      for (int b = 0; b < n; b++) begin
         bit          got;
         logic [31:0] d;
         logic        lst;
         got = 1'b0;
         d   = d0 + step * b;
         lst = with_last && (b == n - 1);
         r_q.push_back({m[0], d, rid, 2'(b), lst});
         s_rvalid = 1'b1; s_rdata = d; s_rid = rid; s_rresp = 2'(b); s_rlast = lst;
         for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            if (m == 0) chk("m1_quiet", {31'd0, m1_rvalid, m1_rdata}, 64'd0);
            else        chk("m0_quiet", {31'd0, m0_rvalid, m0_rdata}, 64'd0);
            chk("no_arready_in_data", {62'd0, m0_arready, m1_arready}, 64'd0);
            if (s_rready) got = 1'b1;
            @(posedge clk); #1;
         end
         if (!got) chk("r_beat_timeout", 64'd0, 64'd1);
      end
      s_rvalid = 1'b0;
      s_rlast  = 1'b0;
   endtask

   initial begin
      #50000;
      $display("FAIL watchdog: got timeout, expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int w;
      m0_arvalid = 1'b0; m0_araddr = '0; m0_arid = '0; m0_arlen = '0; m0_arsize = '0; m0_arburst = '0; m0_rready = 1'b1;
      m1_arvalid = 1'b0; m1_araddr = '0; m1_arid = '0; m1_arlen = '0; m1_arsize = '0; m1_arburst = '0; m1_rready = 1'b1;
      s_arready = 1'b0; s_rvalid = 1'b0; s_rresp = '0; s_rdata = '0; s_rlast = 1'b0; s_rid = '0;

      // Reset: requests and slave beats present, but everything must stay quiet
      m0_arvalid = 1'b1; m0_araddr = 32'h1234; s_rvalid = 1'b1;
      @(posedge clk); #1;
      @(negedge clk);
      chk("rst_arready", {62'd0, m0_arready, m1_arready}, 64'd0);
      chk("rst_s_arvalid", {63'd0, s_arvalid}, 64'd0);
      chk("rst_s_rready", {63'd0, s_rready}, 64'd0);
      chk("rst_rvalid", {62'd0, m0_rvalid, m1_rvalid}, 64'd0);
      chk("rst_s_araddr", {32'd0, s_araddr}, 64'd0);
      @(posedge clk); #1;
      m0_arvalid = 1'b0; s_rvalid = 1'b0; rst = 1'b0;

      // Single m0 burst; m1 requests while m0 is busy
      master_ar(0, 32'h8000_0010, 4'h2, 8'd3, w);
      chk("m0_arready_latency", w, 0);
      m1_araddr = 32'h4000_0020; m1_arid = 4'h7; m1_arlen = 8'd1; m1_arvalid = 1'b1;
      slave_ar(0, 32'h8000_0010, 4'h2, 8'd3);
      slave_r(0, 4, 32'hA0, 32'h1, 4'h2, 1'b1);
      master_ar(1, 32'h4000_0020, 4'h7, 8'd1, w);
      chk("m1_grant_after_rlast", w, 0);

      // Slave AR backpressure with m0 waiting, then R backpressure on m1
      m0_araddr = 32'h0000_0100; m0_arid = 4'h1; m0_arlen = 8'd0; m0_arvalid = 1'b1;
      slave_ar(5, 32'h4000_0020, 4'h7, 8'd1);
      fork
         begin
            for (int i = 0; i < 3; i++) begin
               m1_rready = (i != 1);
               @(negedge clk);
               chk("s_rready_mirror", {63'd0, s_rready}, {63'd0, m1_rready});
               @(posedge clk); #1;
            end
            m1_rready = 1'b1;
         end
         slave_r(1, 2, 32'h11, 32'h11, 4'h7, 1'b1);
      join

      // Contention: both masters keep requesting
      m1_araddr = 32'h0000_0200; m1_arlen = 8'd0; m1_arvalid = 1'b1;
      for (int k = 0; k < 4; k++) begin
         int ew;
`ifdef ARB_ROUND_ROBIN_EN
         ew = (tb_last == 0) ? 1 : 0;
`else
         ew = 0;
`endif
         @(negedge clk);
         chk("cont_m0_arready", {63'd0, m0_arready}, {63'd0, ew == 0});
         chk("cont_m1_arready", {63'd0, m1_arready}, {63'd0, ew == 1});
         if (ew == 0) ar_q.push_back({32'h0000_0100, 4'h1, 8'd0, 3'd2, 2'd1});
         else         ar_q.push_back({32'h0000_0200, 4'h7, 8'd0, 3'd2, 2'd1});
         @(posedge clk); #1;
         tb_last = ew;
         if (ew == 0) slave_ar(0, 32'h0000_0100, 4'h1, 8'd0);
         else         slave_ar(0, 32'h0000_0200, 4'h7, 8'd0);
         slave_r(ew, 1, 32'hC0 + k, 32'h0, (ew == 0) ? 4'h1 : 4'h7, 1'b1);
      end
      m0_arvalid = 1'b0; m1_arvalid = 1'b0;

      // Reset in the middle of an m0 burst, then a fresh m1 request
      master_ar(0, 32'h3000_0000, 4'h3, 8'd3, w);
      slave_ar(0, 32'h3000_0000, 4'h3, 8'd3);
      slave_r(0, 2, 32'hD0, 32'h1, 4'h3, 1'b0);
      rst = 1'b1; s_rvalid = 1'b1; s_rdata = 32'hCC; s_rlast = 1'b0;
      m1_araddr = 32'h5000_0000; m1_arid = 4'h9; m1_arlen = 8'd0; m1_arvalid = 1'b1;
      @(negedge clk);
      chk("mid_rst_m0_rvalid", {63'd0, m0_rvalid}, 64'd0);
      chk("mid_rst_s_rready", {63'd0, s_rready}, 64'd0);
      chk("mid_rst_arready", {62'd0, m0_arready, m1_arready}, 64'd0);
      @(posedge clk); #1;
      rst = 1'b0; s_rvalid = 1'b0; tb_last = 1;
      @(negedge clk);
      chk("post_rst_s_arvalid", {63'd0, s_arvalid}, 64'd0);
      chk("post_rst_s_rready", {63'd0, s_rready}, 64'd0);
      chk("post_rst_grant", {62'd0, m0_arready, m1_arready}, 64'd1);
      ar_q.push_back({32'h5000_0000, 4'h9, 8'd0, 3'd2, 2'd1});
      @(posedge clk); #1;
      m1_arvalid = 1'b0; tb_last = 1;
      slave_ar(0, 32'h5000_0000, 4'h9, 8'd0);
      slave_r(1, 1, 32'h55, 32'h0, 4'h9, 1'b1);

      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("ar_q_drained", ar_q.size(), 0);
      chk("r_q_drained", r_q.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
